uart_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 24 ++
 rtl/uart_rx_byte.sv | 98 +++++++++
 rtl/uart_loader.sv | 146 ++++++++++++++
 tb/tb_uart_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package loader_pkg;

    localparam logic [7:0]  LOADER_HDR       = 8'hA5;
    localparam int unsigned LOADER_LEN_BYTES = 2;
    localparam int unsigned LEN_W            = 8 * LOADER_LEN_BYTES;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        F_HDR,
        F_LENH,
        F_LENL,
        F_DATA,
        F_CSUM,
        F_DONE
    } frame_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 138
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYCLES - 1);

    rx_state_t        state, state_n;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       byte_data_n;
    logic             byte_valid_n, frame_err_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= RX;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_data  <= byte_data_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Bit-timing FSM; counter restarts at every sample point so samples stay mid-bit.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt + CNT_W'(1);
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        byte_data_n  = byte_data;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (state)
            R_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync) state_n = R_START;
            end
            R_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_sync, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = R_STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            R_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    state_n = R_IDLE;
                    if (rx_sync) begin
                        byte_valid_n = 1'b1;
                        byte_data_n  = shreg;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_loader.sv
// Framed UART program loader: writes big-endian words to program RAM, releases HOLD on valid checksum.
module uart_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_WORDS  = 2048
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX,
    output logic                  WEN,
    output logic [ADDR_WIDTH-1:0] WADDR,
    output logic [31:0]           WDATA,
    output logic                  HOLD,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    frame_state_t          state, state_n;
    logic [LEN_W-1:0]      len, len_n, new_len, word_cnt, word_cnt_n, word_cnt_inc;
    logic [1:0]            byte_idx, byte_idx_n;
    logic [23:0]           word_sh, word_sh_n;
    logic [7:0]            csum, csum_n;
    logic                  wen_n, hold_n, done_n, err_n;
    logic [ADDR_WIDTH-1:0] waddr_n;
    logic [31:0]           wdata_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= F_HDR;
            len      <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            word_sh  <= '0;
            csum     <= '0;
            WEN      <= 1'b0;
            WADDR    <= '0;
            WDATA    <= '0;
            HOLD     <= 1'b1;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            word_cnt <= word_cnt_n;
            byte_idx <= byte_idx_n;
            word_sh  <= word_sh_n;
            csum     <= csum_n;
            WEN      <= wen_n;
            WADDR    <= waddr_n;
            WDATA    <= wdata_n;
            HOLD     <= hold_n;
            DONE     <= done_n;
            ERR      <= err_n;
        end
    end

    assign new_len      = {len[LEN_W-1:8], byte_data};
    assign word_cnt_inc = word_cnt + LEN_W'(1);

    // Frame parser; a receiver framing error aborts any frame still in progress.
    always_comb begin
        state_n    = state;
        len_n      = len;
        word_cnt_n = word_cnt;
        byte_idx_n = byte_idx;
        word_sh_n  = word_sh;
        csum_n     = csum;
        wen_n      = 1'b0;
        waddr_n    = WEN ? WADDR + ADDR_WIDTH'(1) : WADDR;
        wdata_n    = WDATA;
        hold_n     = HOLD;
        done_n     = DONE;
        err_n      = ERR;
        if (frame_err && state != F_DONE) begin
            err_n   = 1'b1;
            state_n = F_HDR;
        end else if (byte_valid) begin
            case (state)
                F_HDR: begin
                    if (byte_data == LOADER_HDR) begin
                        err_n      = 1'b0;
                        waddr_n    = '0;
                        csum_n     = '0;
                        byte_idx_n = '0;
                        word_cnt_n = '0;
                        state_n    = F_LENH;
                    end
                end
                F_LENH: begin
                    len_n   = {byte_data, len[7:0]};
                    state_n = F_LENL;
                end
                F_LENL: begin
                    len_n = new_len;
                    if (new_len == '0 || new_len > LEN_W'(MAX_WORDS)) begin
                        err_n   = 1'b1;
                        state_n = F_HDR;
                    end else begin
                        state_n = F_DATA;
                    end
                end
                F_DATA: begin
                    csum_n     = csum ^ byte_data;
                    word_sh_n  = {word_sh[15:0], byte_data};
                    byte_idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        wen_n      = 1'b1;
                        wdata_n    = {word_sh, byte_data};
                        word_cnt_n = word_cnt_inc;
                        if (word_cnt_inc == len) state_n = F_CSUM;
                    end
                end
                F_CSUM: begin
                    if (byte_data == csum) begin
                        done_n  = 1'b1;
                        hold_n  = 1'b0;
                        state_n = F_DONE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = F_HDR;
                    end
                end
                F_DONE: state_n = F_DONE;
                default: state_n = F_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: valid load, checksum/length/framing errors, noise, reset.
module tb_uart_loader;

    localparam int unsigned CLK_HZ = 16000000;
    localparam int unsigned BAUD   = 1000000;
    localparam int unsigned BITC   = CLK_HZ / BAUD;
    localparam int unsigned AW     = 11;
    localparam int unsigned MAXW   = 2048;

    logic          CLK, RST, RX;
    logic          WEN, HOLD, DONE, ERR;
    logic [AW-1:0] WADDR;
    logic [31:0]   WDATA;

    uart_loader #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .ADDR_WIDTH (AW),
        .MAX_WORDS  (MAXW)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .RX    (RX),
        .WEN   (WEN),
        .WADDR (WADDR),
        .WDATA (WDATA),
        .HOLD  (HOLD),
        .DONE  (DONE),
        .ERR   (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Image: words 0x12345678, 0xDEADBEEF.
    logic [7:0] img [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] good_cs;

    function automatic logic [7:0] img_csum();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ img[i];
        return x;
    endfunction

    // Write-port and receiver monitor, sampled on the falling edge.
    logic [AW-1:0] wa_q [$];
    logic [31:0]   wd_q [$];
    int            bv_cnt = 0, wen_wide = 0, hold_done = 0;
    logic          wen_prev = 1'b0;

    always @(negedge CLK) begin
        if (WEN) begin
            wa_q.push_back(WADDR);
            wd_q.push_back(WDATA);
        end
        if (WEN && wen_prev) wen_wide++;
        wen_prev = WEN;
        if (dut.u_rx.byte_valid) bv_cnt++;
        if (DONE && HOLD) hold_done++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge CLK);
        RX = 1'b0;
        repeat (BITC) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BITC) @(negedge CLK);
        end
        RX = stop;
        repeat (BITC) @(negedge CLK);
        RX = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic send_body(input logic [7:0] cs);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(img[i], 1'b1);
        send_byte(cs, 1'b1);
        repeat (20) @(negedge CLK);
    endtask

    task automatic send_img(input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        send_body(cs);
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        clear_q();
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() >= 2) begin
            check({tag, "_a0"}, 32'(wa_q[0]), 32'd0);
            check({tag, "_d0"}, wd_q[0], 32'h12345678);
            check({tag, "_a1"}, 32'(wa_q[1]), 32'd1);
            check({tag, "_d1"}, wd_q[1], 32'hDEADBEEF);
        end
    endtask

    initial begin
        good_cs = img_csum();
        RST = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_wen",   32'(WEN),   32'd0);
        check("rst_waddr", 32'(WADDR), 32'd0);
        check("rst_wdata", WDATA,      32'd0);
        check("rst_hold",  32'(HOLD),  32'd1);
        check("rst_done",  32'(DONE),  32'd0);
        check("rst_err",   32'(ERR),   32'd0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Short low glitch on idle line must not produce a byte.
        RX = 1'b0;
        repeat (BITC * 3 / 10) @(negedge CLK);
        RX = 1'b1;
        repeat (BITC * 3) @(negedge CLK);
        check("glitch_bv", 32'(bv_cnt), 32'd0);

        send_img(good_cs);
        check_writes("valid");
        check("valid_done",  32'(DONE),  32'd1);
        check("valid_hold",  32'(HOLD),  32'd0);
        check("valid_err",   32'(ERR),   32'd0);
        check("valid_waddr", 32'(WADDR), 32'd2);

        clear_q();
        send_img(good_cs);
        check("absorb_nwr",  32'(wa_q.size()), 32'd0);
        check("absorb_done", 32'(DONE), 32'd1);

        do_reset();
        send_img(good_cs ^ 8'h01);
        check_writes("badcs");
        check("badcs_err",  32'(ERR),  32'd1);
        check("badcs_hold", 32'(HOLD), 32'd1);
        check("badcs_done", 32'(DONE), 32'd0);
        clear_q();
        send_byte(8'hA5, 1'b1);
        check("hdr_clr_err", 32'(ERR), 32'd0);
        send_body(good_cs);
        check_writes("resend");
        check("resend_done", 32'(DONE), 32'd1);

        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("len0_err", 32'(ERR), 32'd1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h08, 1'b1);
        check("lenbig_mid_err", 32'(ERR), 32'd0);
        send_byte(8'h01, 1'b1);
        check("lenbig_err",  32'(ERR), 32'd1);
        check("badlen_nwr",  32'(wa_q.size()), 32'd0);
        check("badlen_hold", 32'(HOLD), 32'd1);

        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        repeat (20) @(negedge CLK);
        check("ferr_err", 32'(ERR), 32'd1);
        check("ferr_nwr", 32'(wa_q.size()), 32'd0);
        send_img(good_cs);
        check_writes("after_ferr");
        check("after_ferr_done", 32'(DONE), 32'd1);

        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        check("garbage_err", 32'(ERR), 32'd0);
        send_img(good_cs);
        check_writes("garbage");
        check("garbage_done", 32'(DONE), 32'd1);

        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b1);
        check("mid_waddr", 32'(WADDR), 32'd1);
        check("mid_wdata", WDATA,      32'h12345678);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midrst_wen",   32'(WEN),   32'd0);
        check("midrst_waddr", 32'(WADDR), 32'd0);
        check("midrst_wdata", WDATA,      32'd0);
        check("midrst_hold",  32'(HOLD),  32'd1);
        check("midrst_done",  32'(DONE),  32'd0);
        check("midrst_err",   32'(ERR),   32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        check("wen_width", 32'(wen_wide),  32'd0);
        check("done_hold", 32'(hold_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
